in_synch: RTL and testbench

Input-side synchroniser for the stereovision AXI4-Stream video path. It accepts a back-pressurable AXI4-Stream (tuser = start of frame, tlast = end of line) and produces the internal free-running pixel stream that the processing core consumes. That internal stream has no ready signal. The block aligns to the first start of frame after reset and enforces exactly TLAST_CYCLES idle output cycles after every end-of-line beat. This is the blanking gap that the output synchroniser expects to absorb at the far end of the pipeline.

---
 rtl/in_synch.sv | 147 ++++++++++++++
 tb/tb_in_synch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_synch.sv
`default_nettype none
// ============================================================================
//  Module      : in_synch
//  Description : Input-side synchroniser for the stereovision AXI4-Stream
//                video path. Aligns to the first start of frame after reset,
//                forwards beats onto a ready-less internal pixel stream with
//                one cycle of latency, and inserts exactly TLAST_CYCLES idle
//                output cycles after every end-of-line beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module in_synch #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int TLAST_CYCLES     = 10
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // Upstream AXI4-Stream (back-pressurable)
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    // Internal free-running pixel stream (no ready)
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    // Start of frame seen in the middle of a line
    output logic                        sof_err
);

    // Counter sized to hold TLAST_CYCLES; it only counts down from a reload.
    localparam int CNT_W = $clog2(TLAST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TLAST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PASS     = 2'd1,
        BLANK    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        line_active_q, line_active_d;
    logic                        tready_q, tready_d;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        tuser_q, tuser_d;
    logic                        sof_err_q, sof_err_d;

    logic                        accept;
    logic                        fwd;

    // Handshake uses the registered ready, so acceptance is a pure Moore function.
    assign accept = s_axis_tvalid & tready_q;

    // Next-state, counter, line tracking and output-register inputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_active_d = line_active_q;
        fwd           = 1'b0;
        sof_err_d     = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                line_active_d = 1'b0;
                if (accept && s_axis_tuser) begin
                    fwd = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = BLANK;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = PASS;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    fwd = 1'b1;
                    // A new frame mid-line is passed through but flagged.
                    sof_err_d = s_axis_tuser & line_active_q;
                    if (s_axis_tlast) begin
                        state_d = BLANK;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BLANK: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = PASS;
                end
            end
            default: begin
                state_d = WAIT_SOF;
            end
        endcase

        // A forwarded beat decides whether a line is in progress.
        if (fwd) begin
            line_active_d = ~s_axis_tlast;
        end

        tready_d = (state_d != BLANK);
        tvalid_d = fwd;
        tlast_d  = fwd & s_axis_tlast;
        tuser_d  = fwd & s_axis_tuser;
        tdata_d  = fwd ? s_axis_tdata : tdata_q;
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= WAIT_SOF;
            cnt_q         <= '0;
            line_active_q <= 1'b0;
            tready_q      <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_active_q <= line_active_d;
            tready_q      <= tready_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            sof_err_q     <= sof_err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign sof_err       = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_in_synch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_in_synch
//  Description : Directed self-checking bench for in_synch. A main instance
//                uses TLAST_CYCLES = 10; a second instance uses
//                TLAST_CYCLES = 1 for the one-pixel-line case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_in_synch;

    logic        aclk;
    logic        aresetn;

    // Main instance (TLAST_CYCLES = 10)
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, m_sof_err;

    // Short-blank instance (TLAST_CYCLES = 1)
    logic [31:0] s1_tdata;
    logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic [31:0] m1_tdata;
    logic        m1_tvalid, m1_tlast, m1_tuser, m1_sof_err;

    int n_checks = 0;
    int n_errors = 0;

    in_synch #(.AXIS_TDATA_WIDTH(32), .TLAST_CYCLES(10)) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .sof_err       (m_sof_err)
    );

    in_synch #(.AXIS_TDATA_WIDTH(32), .TLAST_CYCLES(1)) u_dut1 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s1_tdata),
        .s_axis_tvalid (s1_tvalid),
        .s_axis_tready (s1_tready),
        .s_axis_tlast  (s1_tlast),
        .s_axis_tuser  (s1_tuser),
        .m_axis_tdata  (m1_tdata),
        .m_axis_tvalid (m1_tvalid),
        .m_axis_tlast  (m1_tlast),
        .m_axis_tuser  (m1_tuser),
        .sof_err       (m1_sof_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic u, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
    endtask

    task automatic drive1(input logic v, input logic [31:0] d, input logic u, input logic l);
        s1_tvalid = v;
        s1_tdata  = d;
        s1_tuser  = u;
        s1_tlast  = l;
    endtask

    // Ten blanking cycles after a tlast beat: output idle, ready back on the last.
    task automatic blank10(input string tag);
        for (int j = 1; j <= 10; j++) begin
            tick();
            check({tag, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
            check({tag, "_tready"}, {31'd0, s_tready}, (j == 10) ? 32'd1 : 32'd0);
        end
    endtask

    // Bubble pattern: valid, idle, valid, idle, valid, valid(tlast)
    logic        bv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] bd [6] = '{32'h20, 32'hEE, 32'h21, 32'hEE, 32'h22, 32'h23};
    logic [31:0] bq [6] = '{32'h20, 32'h20, 32'h21, 32'h21, 32'h22, 32'h23};
    logic        bl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive1(1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- Reset state ----------------
        repeat (3) tick();
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tdata",  m_tdata, 32'd0);
        check("rst_tlast",  {31'd0, m_tlast}, 32'd0);
        check("rst_tuser",  {31'd0, m_tuser}, 32'd0);
        check("rst_soferr", {31'd0, m_sof_err}, 32'd0);
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        aresetn = 1'b1;
        tick();
        check("rel_tready", {31'd0, s_tready}, 32'd1);

        // ---------------- Beats before SOF are dropped ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + i, 1'b0, 1'b0);
            tick();
            check("presof_tvalid", {31'd0, m_tvalid}, 32'd0);
            check("presof_tready", {31'd0, s_tready}, 32'd1);
        end
        drive(1'b1, 32'hA0, 1'b1, 1'b1);
        tick();
        check("sof_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("sof_tdata",  m_tdata, 32'hA0);
        check("sof_tuser",  {31'd0, m_tuser}, 32'd1);
        check("sof_tlast",  {31'd0, m_tlast}, 32'd1);
        check("sof_soferr", {31'd0, m_sof_err}, 32'd0);
        check("sof_tready", {31'd0, s_tready}, 32'd0);
        drive(1'b1, 32'h00, 1'b0, 1'b0);
        blank10("blankA");

        // ---------------- 8-beat line, source always valid ----------------
        for (int i = 0; i < 8; i++) begin
            tick();
            check("line_tvalid", {31'd0, m_tvalid}, 32'd1);
            check("line_tdata",  m_tdata, 32'(i));
            check("line_tlast",  {31'd0, m_tlast}, (i == 7) ? 32'd1 : 32'd0);
            check("line_tuser",  {31'd0, m_tuser}, 32'd0);
            if (i < 6)       drive(1'b1, 32'(i + 1), 1'b0, 1'b0);
            else if (i == 6) drive(1'b1, 32'h07, 1'b0, 1'b1);
            else             drive(1'b1, 32'h20, 1'b0, 1'b0);
        end
        check("line_end_tready", {31'd0, s_tready}, 32'd0);
        blank10("blankB");

        // ---------------- Source bubbles pass through ----------------
        for (int c = 0; c < 6; c++) begin
            drive(bv[c], bd[c], 1'b0, bl[c]);
            tick();
            check("bub_tvalid", {31'd0, m_tvalid}, {31'd0, bv[c]});
            check("bub_tdata",  m_tdata, bq[c]);
            check("bub_tlast",  {31'd0, m_tlast}, {31'd0, bl[c]});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        blank10("blankC");

        // ---------------- Mid-line SOF ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h30 + i, (i == 2), (i == 5));
            tick();
            check("mid_tvalid", {31'd0, m_tvalid}, 32'd1);
            check("mid_tdata",  m_tdata, 32'h30 + i);
            check("mid_tuser",  {31'd0, m_tuser}, (i == 2) ? 32'd1 : 32'd0);
            check("mid_soferr", {31'd0, m_sof_err}, (i == 2) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        blank10("blankD");

        // ---------------- Reset during BLANK ----------------
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        check("rb_tdata40", m_tdata, 32'h40);
        drive(1'b1, 32'h41, 1'b0, 1'b1);
        tick();
        check("rb_tlast41", {31'd0, m_tlast}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) tick();
        aresetn = 1'b0;
        #1;
        check("rb_tdata",  m_tdata, 32'd0);
        check("rb_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rb_tready", {31'd0, s_tready}, 32'd0);
        check("rb_tlast",  {31'd0, m_tlast}, 32'd0);
        #2;
        aresetn = 1'b1;
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        tick();
        check("rb_rel_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rb_rel_tready", {31'd0, s_tready}, 32'd1);
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 32'h50 + i, 1'b0, 1'b0);
            tick();
            check("rb_drop_tvalid", {31'd0, m_tvalid}, 32'd0);
        end
        drive(1'b1, 32'h60, 1'b1, 1'b0);
        tick();
        check("rb_sof_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("rb_sof_tdata",  m_tdata, 32'h60);
        check("rb_sof_tuser",  {31'd0, m_tuser}, 32'd1);
        check("rb_sof_soferr", {31'd0, m_sof_err}, 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // ---------------- Single-beat line, TLAST_CYCLES = 1 ----------------
        drive1(1'b1, 32'h55, 1'b1, 1'b1);
        tick();
        check("one_tvalid", {31'd0, m1_tvalid}, 32'd1);
        check("one_tdata",  m1_tdata, 32'h55);
        check("one_tuser",  {31'd0, m1_tuser}, 32'd1);
        check("one_tlast",  {31'd0, m1_tlast}, 32'd1);
        check("one_tready", {31'd0, s1_tready}, 32'd0);
        drive1(1'b1, 32'h56, 1'b0, 1'b0);
        tick();
        check("one_idle_tvalid", {31'd0, m1_tvalid}, 32'd0);
        check("one_idle_tready", {31'd0, s1_tready}, 32'd1);
        tick();
        check("one_next_tvalid", {31'd0, m1_tvalid}, 32'd1);
        check("one_next_tdata",  m1_tdata, 32'h56);
        drive1(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
